// File: rtl/bash_f_iter.sv
// bash_f_iter -- iterative bash-f sponge permutation core (STB 34.101.77).
//
// The 1536-bit state is held in one register. Each RUN cycle applies UNROLL
// chained rounds. A full job takes 24/UNROLL cycles from the accepting edge
// to out_valid_o.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   in_valid_i   input state offered
//   in_ready_o   core accepts input (IDLE only)
//   state_i      input state, word k at [k*SLEN +: SLEN]
//   out_valid_o  result available (DONE)
//   out_ready_i  consumer takes the result
//   state_o      result, same word order as state_i
//   busy_o       rounds in progress (RUN)
//   round_o      index of the next round to run while in RUN, else 0
//   abort_i      only with BASH_F_ITER_ABORT_EN: drops the job in RUN/DONE
//
// Optional feature macro: BASH_F_ITER_ABORT_EN (adds abort_i).

package bash_hash_params_pkg;
  localparam int SLEN = 64;

  // Per-lane rotation amounts of bash-s. Each lane multiplies the previous
  // lane's values by 7 mod 64.
  localparam int BASH_M1 [8] = '{8, 56, 8, 56, 8, 56, 8, 56};
  localparam int BASH_N1 [8] = '{53, 51, 37, 3, 21, 19, 5, 35};
  localparam int BASH_M2 [8] = '{14, 34, 46, 2, 14, 34, 46, 2};
  localparam int BASH_N2 [8] = '{1, 7, 49, 23, 33, 39, 17, 55};

  localparam logic [SLEN-1:0] BASH_F_C [24] = '{
    64'h3BF5080AC8BA94B1, 64'hC1D1659C1BBD92F6, 64'h60E8B2CE0DDEC97B,
    64'hEC5FB8FE790FBC13, 64'hAA043DE6436706A7, 64'h8929FF6A5E535BFD,
    64'h98BF1E2C50C97550, 64'h4C5F8F162864BAA8, 64'h262FC78B14325D54,
    64'h1317E3C58A192EAA, 64'h098BF1E2C50C9755, 64'hD8EE19681D669304,
    64'h6C770CB40EB34982, 64'h363B865A0759A4C1, 64'hC73622B47C4C0ACE,
    64'h639B115A3E260567, 64'hEDE6693460F3DA1D, 64'hAAD8D5034F9935A0,
    64'h556C6A81A7CC9AD0, 64'h2AB63540D3E64D68, 64'h155B1AA069F326B4,
    64'h0AAD8D5034F9935A, 64'h0556C6A81A7CC9AD, 64'hDE8082CD72DEBC78
  };
endpackage

module bash_f_iter
  import bash_hash_params_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [24*SLEN-1:0] state_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [24*SLEN-1:0] state_o,
  output logic               busy_o,
  output logic [4:0]         round_o
`ifdef BASH_F_ITER_ABORT_EN
  ,
  input  logic               abort_i
`endif
);

  localparam int SW = 24 * SLEN;
  localparam logic [4:0] STEP = 5'(UNROLL);
  localparam logic [4:0] LAST = 5'(24 - UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 ||
        UNROLL == 6 || UNROLL == 8 || UNROLL == 12 || UNROLL == 24)) begin : g_bad_unroll
    $error("bash_f_iter: UNROLL=%0d is not a divisor of 24", UNROLL);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t          fsm_q;
  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [4:0]    cnt_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          abort;

`ifdef BASH_F_ITER_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [SLEN-1:0] rotl(input logic [SLEN-1:0] x, input int n);
    return (x << n) | (x >> (SLEN - n));
  endfunction

  // bash-s S-box on one lane; result packed as {w2, w1, w0}.
  function automatic logic [3*SLEN-1:0] bash_s(input logic [SLEN-1:0] a0, a1, a2,
                                               input int m1, n1, m2, n2);
    logic [SLEN-1:0] w0, w1, w2, t1;
    w0 = a0 ^ a1 ^ a2;
    t1 = a1 ^ rotl(w0, n1);
    w1 = rotl(a1, m1) ^ t1;
    w2 = a2 ^ rotl(a2, m2) ^ rotl(t1, n2);
    return {w2 ^ (w0 & w1), w1 ^ (w0 | w2), w0 ^ (w1 | ~w2)};
  endfunction

  // One full round: 8 lanes, word permutation, constant into word 23.
  function automatic logic [SW-1:0] bash_round(input logic [SW-1:0] s, input logic [SLEN-1:0] c);
    logic [23:0][SLEN-1:0] w, y, r;
    w = s;
    {y[16], y[8],  y[0]} = bash_s(w[0], w[8],  w[16], BASH_M1[0], BASH_N1[0], BASH_M2[0], BASH_N2[0]);
    {y[17], y[9],  y[1]} = bash_s(w[1], w[9],  w[17], BASH_M1[1], BASH_N1[1], BASH_M2[1], BASH_N2[1]);
    {y[18], y[10], y[2]} = bash_s(w[2], w[10], w[18], BASH_M1[2], BASH_N1[2], BASH_M2[2], BASH_N2[2]);
    {y[19], y[11], y[3]} = bash_s(w[3], w[11], w[19], BASH_M1[3], BASH_N1[3], BASH_M2[3], BASH_N2[3]);
    {y[20], y[12], y[4]} = bash_s(w[4], w[12], w[20], BASH_M1[4], BASH_N1[4], BASH_M2[4], BASH_N2[4]);
    {y[21], y[13], y[5]} = bash_s(w[5], w[13], w[21], BASH_M1[5], BASH_N1[5], BASH_M2[5], BASH_N2[5]);
    {y[22], y[14], y[6]} = bash_s(w[6], w[14], w[22], BASH_M1[6], BASH_N1[6], BASH_M2[6], BASH_N2[6]);
    {y[23], y[15], y[7]} = bash_s(w[7], w[15], w[23], BASH_M1[7], BASH_N1[7], BASH_M2[7], BASH_N2[7]);
    // Output word k takes y[P[k]] with P = 15,10,9,12,11,14,13,8,17,16,19,18,
    // 21,20,23,22,6,3,0,5,2,7,4,1; listed here from word 23 down to word 0.
    r = {y[1],  y[4],  y[7],  y[2],  y[5],  y[0],  y[3],  y[6],
         y[22], y[23], y[20], y[21], y[18], y[19], y[16], y[17],
         y[8],  y[13], y[14], y[11], y[12], y[9],  y[10], y[15]};
    r[23] = r[23] ^ c;
    return r;
  endfunction

  // cnt_q + UNROLL never exceeds 24 in RUN, so every constant index is valid.
  always_comb begin
    state_d = state_q;
    for (int u = 0; u < UNROLL; u++) begin
      state_d = bash_round(state_d, BASH_F_C[cnt_q + 5'(u)]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid_i && in_ready_q) begin
            state_q    <= state_i;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            fsm_q      <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            fsm_q      <= IDLE;
          end else begin
            state_q <= state_d;
            if (cnt_q == LAST) begin
              cnt_q       <= '0;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
              fsm_q       <= DONE;
            end else begin
              cnt_q <= cnt_q + STEP;
            end
          end
        end
        DONE: begin
          if (abort || out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          cnt_q       <= '0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          fsm_q       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign round_o     = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bash_f_iter.sv
// Bench for bash_f_iter: three instances (UNROLL = 1, 4, 24) checked
// against a behavioural bash-f model through per-instance scoreboards.
module tb_bash_f_iter;
  import bash_hash_params_pkg::*;

  localparam int SWB = 24 * SLEN;

  logic clk = 1'b0;
  logic rst_n;
  logic iv1, ivx, or1, orx;
  logic [SWB-1:0] st_in;
`ifdef BASH_F_ITER_ABORT_EN
  logic abort;
`endif

  logic u1_ir, u1_ov, u1_busy;   logic [4:0] u1_rnd;  logic [SWB-1:0] u1_st;
  logic u4_ir, u4_ov, u4_busy;   logic [4:0] u4_rnd;  logic [SWB-1:0] u4_st;
  logic u24_ir, u24_ov, u24_busy; logic [4:0] u24_rnd; logic [SWB-1:0] u24_st;

  logic [SWB-1:0] q1[$], q4[$], q24[$];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bash_f_iter #(.UNROLL(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(iv1), .in_ready_o(u1_ir),
    .state_i(st_in), .out_valid_o(u1_ov), .out_ready_i(or1), .state_o(u1_st),
    .busy_o(u1_busy), .round_o(u1_rnd)
`ifdef BASH_F_ITER_ABORT_EN
    , .abort_i(abort)
`endif
  );

  bash_f_iter #(.UNROLL(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(ivx), .in_ready_o(u4_ir),
    .state_i(st_in), .out_valid_o(u4_ov), .out_ready_i(orx), .state_o(u4_st),
    .busy_o(u4_busy), .round_o(u4_rnd)
`ifdef BASH_F_ITER_ABORT_EN
    , .abort_i(abort)
`endif
  );

  bash_f_iter #(.UNROLL(24)) u24 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(ivx), .in_ready_o(u24_ir),
    .state_i(st_in), .out_valid_o(u24_ov), .out_ready_i(orx), .state_o(u24_st),
    .busy_o(u24_busy), .round_o(u24_rnd)
`ifdef BASH_F_ITER_ABORT_EN
    , .abort_i(abort)
`endif
  );

  function automatic logic [63:0] rot_hi(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x};
    return d[127-n -: 64];
  endfunction

  // Reference bash-f written step by step from the algorithm description;
  // round constants come from the LFSR that defines them.
  function automatic logic [SWB-1:0] model_f(input logic [SWB-1:0] s_in);
    logic [SWB-1:0] s, t;
    logic [63:0] w0, w1, w2, t0, t1, t2, c;
    int m1, n1, m2, n2;
    int perm [24];
    perm = '{15, 10, 9, 12, 11, 14, 13, 8, 17, 16, 19, 18, 21, 20, 23, 22, 6, 3, 0, 5, 2, 7, 4, 1};
    s = s_in;
    c = 64'h3BF5080AC8BA94B1;
    for (int i = 0; i < 24; i++) begin
      m1 = 8; n1 = 53; m2 = 14; n2 = 1;
      for (int j = 0; j < 8; j++) begin
        w0 = s[j*64 +: 64]; w1 = s[(j+8)*64 +: 64]; w2 = s[(j+16)*64 +: 64];
        t0 = rot_hi(w1, m1);
        w0 = w0 ^ w1 ^ w2;
        t1 = w1 ^ rot_hi(w0, n1);
        w1 = t0 ^ t1;
        w2 = w2 ^ rot_hi(w2, m2) ^ rot_hi(t1, n2);
        t1 = w0 | w2;
        t2 = w0 & w1;
        t0 = ~w2;
        t0 = t0 | w1;
        w0 = w0 ^ t0; w1 = w1 ^ t1; w2 = w2 ^ t2;
        s[j*64 +: 64] = w0; s[(j+8)*64 +: 64] = w1; s[(j+16)*64 +: 64] = w2;
        m1 = (7 * m1) % 64; n1 = (7 * n1) % 64; m2 = (7 * m2) % 64; n2 = (7 * n2) % 64;
      end
      for (int k = 0; k < 24; k++) t[k*64 +: 64] = s[perm[k]*64 +: 64];
      t[23*64 +: 64] = t[23*64 +: 64] ^ c;
      s = t;
      c = c[0] ? ((c >> 1) ^ 64'hDC2BE1997FE0D8AE) : (c >> 1);
    end
    return s;
  endfunction

  function automatic logic [SWB-1:0] rand_state();
    logic [SWB-1:0] r;
    for (int k = 0; k < 48; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_st(input string tag, input logic [SWB-1:0] obs, input logic [SWB-1:0] exp);
    int bad;
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      bad = 0;
      for (int i = 23; i >= 0; i--) if (obs[i*64 +: 64] !== exp[i*64 +: 64]) bad = i;
      $error("FAIL %s: word %0d observed %h expected %h", tag, bad, obs[bad*64 +: 64], exp[bad*64 +: 64]);
    end
  endtask

  // One job on all three instances. hold>0 keeps u1's out_ready low for
  // that many cycles in DONE; poke offers a second input to u1 mid-run.
  task automatic job(input logic [SWB-1:0] s, input int hold, input bit poke);
    logic [SWB-1:0] e, snap;
    int lat1, lat4, lat24;
    e = model_f(s);
    q1.push_back(e); q4.push_back(e); q24.push_back(e);
    or1 = (hold == 0);
    st_in = s; iv1 = 1'b1; ivx = 1'b1;
    @(negedge clk);
    iv1 = 1'b0; ivx = 1'b0; st_in = ~s;
    check("run_busy", u1_busy, 1);
    check("run_in_ready", u1_ir, 0);
    check("run_round0", u1_rnd, 0);
    lat1 = -1; lat4 = -1; lat24 = -1;
    for (int k = 1; k <= 30 && lat1 < 0; k++) begin
      if (poke && k == 5) begin iv1 = 1'b1; st_in = rand_state(); end
      @(negedge clk);
      iv1 = 1'b0;
      if (k == 12) check("u1_round12", u1_rnd, 12);
      if (k == 3) check("u4_round12", u4_rnd, 12);
      if (u24_ov && lat24 < 0) begin
        lat24 = k;
        check("u24_sb_nonempty", q24.size() > 0, 1);
        if (q24.size() > 0) check_st("u24_state", u24_st, q24.pop_front());
      end
      if (u4_ov && lat4 < 0) begin
        lat4 = k;
        check("u4_sb_nonempty", q4.size() > 0, 1);
        if (q4.size() > 0) check_st("u4_state", u4_st, q4.pop_front());
      end
      if (u1_ov && lat1 < 0) begin
        lat1 = k;
        check("u1_sb_nonempty", q1.size() > 0, 1);
        if (q1.size() > 0) check_st("u1_state", u1_st, q1.pop_front());
      end
    end
    check("u1_latency", lat1, 24);
    check("u4_latency", lat4, 6);
    check("u24_latency", lat24, 1);
    if (hold > 0) begin
      snap = u1_st;
      repeat (hold) @(negedge clk);
      check_st("bp_state_stable", u1_st, e);
      check("bp_state_unchanged", (u1_st === snap), 1);
      check("bp_out_valid", u1_ov, 1);
      check("bp_in_ready", u1_ir, 0);
      check("bp_round", u1_rnd, 0);
      or1 = 1'b1;
    end
    @(negedge clk);
    check("post_out_valid", u1_ov, 0);
    check("post_in_ready", u1_ir, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, seen_ov;
    rst_n = 1'b0; iv1 = 1'b0; ivx = 1'b0; or1 = 1'b1; orx = 1'b1; st_in = '0;
`ifdef BASH_F_ITER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready", u1_ir, 0);
    check("rst_out_valid", u1_ov, 0);
    check("rst_busy", u1_busy, 0);
    check("rst_round", u1_rnd, 0);
    check_st("rst_state", u1_st, '0);
    check("rst_in_ready_u24", u24_ir, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", u1_ir, 0);
    @(negedge clk);
    check("rel_in_ready", u1_ir, 1);
    check("rel_in_ready_u4", u4_ir, 1);

    // bash-f of the zero state, then all-ones and zero back to back.
    job('0, 0, 0);
    job('1, 0, 0);
    job('0, 0, 0);
    // Random state with backpressure and an input offered during RUN.
    job(rand_state(), 10, 1);
    job(rand_state(), 0, 0);

    // Reset in the middle of a job.
    st_in = rand_state(); iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (u1_rnd == 5'd11) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_round11", found, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", u1_ir, 0);
    check("mid_rst_out_valid", u1_ov, 0);
    check("mid_rst_busy", u1_busy, 0);
    check("mid_rst_round", u1_rnd, 0);
    check_st("mid_rst_state", u1_st, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_ov = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (u1_ov) seen_ov = 1'b1;
    end
    check("mid_rst_no_output", seen_ov, 0);
    check("mid_rst_in_ready_back", u1_ir, 1);
    job(rand_state(), 0, 0);

`ifdef BASH_F_ITER_ABORT_EN
    // Abort held in IDLE has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_in_ready", u1_ir, 1);
    check("abort_idle_busy", u1_busy, 0);
    // Abort at round 5 drops the job.
    st_in = rand_state(); iv1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (u1_rnd == 5'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_round5", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_in_ready", u1_ir, 1);
    check("abort_busy", u1_busy, 0);
    check("abort_round", u1_rnd, 0);
    check("abort_out_valid", u1_ov, 0);
    seen_ov = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (u1_ov) seen_ov = 1'b1;
    end
    check("abort_no_output", seen_ov, 0);
    job(rand_state(), 0, 0);
`endif

    check("sb1_empty", q1.size(), 0);
    check("sb4_empty", q4.size(), 0);
    check("sb24_empty", q24.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bash_f_iter.md
BASH_F_ITER -- requirements
Module: bash_f_iter

Interface
REQ-001 SHALL have parameter UNROLL, default 1: bash-f rounds per clock; legal values 1,2,3,4,6,8,12,24.
REQ-002 SHALL take SLEN (64) from bash_hash_params_pkg; state width SW = 24*SLEN.
REQ-003 SHALL have port clk_i, input, 1 bit: the only clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid_i, input, 1 bit: input state offered.
REQ-006 SHALL have port in_ready_o, output, 1 bit: core accepts input.
REQ-007 SHALL have port state_i, input, SW bits: word k at [k*SLEN +: SLEN].
REQ-008 SHALL have port out_valid_o, output, 1 bit: result available.
REQ-009 SHALL have port out_ready_i, input, 1 bit: consumer takes result.
REQ-010 SHALL have port state_o, output, SW bits: result, same word order as state_i.
REQ-011 SHALL have port busy_o, output, 1 bit: rounds in progress.
REQ-012 SHALL have port round_o, output, 5 bits: index of the next round to run, 0..23.

Function
REQ-013 One round = 8 parallel bash_s on words (i, i+8, i+16), using per-lane M1/N1/M2/N2 from bash_hash_params_pkg.
REQ-014 Each round SHALL then apply the fixed word permutation and XOR round constant BASH_F_C[r] (24-entry package table) into word 23.
REQ-015 Output word mapping, outputs 0..23 from bash_s outputs: 15,10,9,12,11,14,13,8,17,16,19,18,21,20,23,22,6,3,0,5,2,7,4,1.
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready_o=1; on in_valid_i&&in_ready_o, register state_i, set round counter to 0, go to RUN.
REQ-018 RUN: each cycle apply UNROLL chained rounds with constants r..r+UNROLL-1, then r += UNROLL.
REQ-019 RUN: when r+UNROLL == 24, the cycle's result SHALL be registered and the FSM SHALL go to DONE.
REQ-020 Latency: out_valid_o SHALL rise exactly 24/UNROLL cycles after the accepting edge.
REQ-021 DONE: out_valid_o=1 and state_o stable until out_valid_o&&out_ready_i, then IDLE.
REQ-022 in_valid_i SHALL be ignored outside IDLE; in_ready_o=0 in RUN and DONE.
REQ-023 out_ready_i SHALL be ignored outside DONE.
REQ-024 state_o SHALL always equal the state register; it is meaningful only while out_valid_o=1.
REQ-025 busy_o=1 exactly in RUN; round_o = counter in RUN, 0 in IDLE and DONE.
REQ-026 An illegal UNROLL SHALL cause an elaboration-time error.

Reset
REQ-027 rst_ni low SHALL immediately force IDLE, state register 0, counter 0.
REQ-028 In reset: in_ready_o=0, out_valid_o=0, busy_o=0, round_o=0, state_o=0.
REQ-029 in_ready_o SHALL go to 1 on the first edge after release.
REQ-030 Reset mid-RUN or mid-DONE SHALL discard the job with no output.

Configuration
REQ-031 Macro BASH_F_ITER_ABORT_EN defined: adds input abort_i (1 bit).
REQ-032 With the macro, abort_i=1 in RUN or DONE SHALL return the core to IDLE next edge, clear the counter, and emit no out_valid_o; abort_i SHALL override an in-flight acceptance.
REQ-033 With the macro, abort_i SHALL be ignored in IDLE.
REQ-034 Without the macro: port absent; behaviour per REQ-016..025.

Verification
REQ-035 UNROLL=1, state_i=0, out_ready_i=1: out_valid_o at +24 cycles; state_o = golden C model of bash-f(0).
REQ-036 UNROLL=4 and UNROLL=24, random state: out_valid_o at +6 and +1 cycles; result equals the UNROLL=1 result.
REQ-037 Backpressure: out_ready_i=0 for 10 cycles in DONE -> state_o stable, in_ready_o=0; input during RUN ignored.
REQ-038 Reset at round_o=11 -> all outputs 0 immediately, no out_valid_o; next job correct.
REQ-039 Two back-to-back jobs (state_i=all-ones, then 0) -> two correct results in order, each with 24/UNROLL latency.
REQ-040 BASH_F_ITER_ABORT_EN, abort_i at round_o=5 -> IDLE next cycle, no out_valid_o; following job correct.
